// File: rtl/cache_if_pkg.sv
// Shared definitions for the cache refill/writeback interface: request type
// codes, line geometry and the memory responder's FSM state encoding.
package cache_if_pkg;

    localparam logic [2:0] RT_BYTE = 3'b000;
    localparam logic [2:0] RT_HALF = 3'b001;
    localparam logic [2:0] RT_WORD = 3'b010;
    localparam logic [2:0] RT_LINE = 3'b100;

    localparam int LINE_BEATS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RWAIT,
        ST_RBEAT,
        ST_WWAIT,
        ST_WCOMMIT
    } state_t;

    // Only the line code selects a burst; every other code behaves as a word.
    function automatic logic is_line(input logic [2:0] t);
        case (t)
            RT_LINE:                   is_line = 1'b1;
            RT_BYTE, RT_HALF, RT_WORD: is_line = 1'b0;
            default:                   is_line = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-addressed backing RAM: asynchronous read, byte-enabled single-word
// write and a whole-line write. Contents are deliberately never reset.
module mem_word_ram
    import cache_if_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_g,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [31:0]       rd_word,
    input  logic              word_we,
    input  logic [ADDR_W-1:0] word_idx,
    input  logic [3:0]        word_be,
    input  logic [31:0]       word_data,
    input  logic              line_we,
    input  logic [ADDR_W-3:0] line_idx,
    input  logic [127:0]      line_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    assign rd_word = mem[rd_idx];

    // Word k of the line lives at {line_idx, k}; data word k is wr_data[32k+31:32k].
    always_ff @(posedge clk_g) begin
        if (line_we) begin
            for (int k = 0; k < LINE_BEATS; k++) begin
                mem[{line_idx, 2'(k)}] <= line_data[32*k +: 32];
            end
        end else if (word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (word_be[b]) begin
                    mem[word_idx][8*b +: 8] <= word_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache: serves one read or write at a time
// from mem_word_ram with programmable latency and 4-beat line bursts.
module cache_mem_responder
    import cache_if_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2
) (
    input  logic         clk_g,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    state_t            state, state_n;
    logic [3:0]        lat_cnt, lat_n;
    logic [1:0]        beat_cnt, beat_n;
    logic [1:0]        last_beat;
    logic [ADDR_W-1:0] addr_q;
    logic              line_q;
    logic [3:0]        wstrb_q;
    logic [127:0]      wdata_q;
    logic              rd_accept, wr_accept;
    logic              ram_word_we, ram_line_we;
    logic              rd_line, wr_line;
    logic [ADDR_W-1:0] rd_word_idx, wr_word_idx;
    logic [31:0]       ram_rd_word;
    logic              unused_addr_bits;

    // Upper address bits alias; line requests drop the in-line word offset.
    assign rd_line     = is_line(rd_type);
    assign wr_line     = is_line(wr_type);
    assign rd_word_idx = rd_line ? {rd_addr[ADDR_W+1:4], 2'b00} : rd_addr[ADDR_W+1:2];
    assign wr_word_idx = wr_line ? {wr_addr[ADDR_W+1:4], 2'b00} : wr_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    assign last_beat = line_q ? 2'(LINE_BEATS - 1) : 2'd0;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            lat_cnt  <= lat_n;
            beat_cnt <= beat_n;
        end
    end

    // Request fields are captured only on the accept cycle.
    always_ff @(posedge clk_g) begin
        if (rd_accept) begin
            addr_q <= rd_word_idx;
            line_q <= rd_line;
        end else if (wr_accept) begin
            addr_q  <= wr_word_idx;
            line_q  <= wr_line;
            wstrb_q <= wr_wstrb;
            wdata_q <= wr_data;
        end
    end

    // Writes win a same-cycle collision so a victim writeback precedes its refill.
    always_comb begin
        state_n     = state;
        lat_n       = lat_cnt;
        beat_n      = beat_cnt;
        rd_accept   = 1'b0;
        wr_accept   = 1'b0;
        ram_word_we = 1'b0;
        ram_line_we = 1'b0;
        case (state)
            ST_IDLE: begin
                lat_n  = '0;
                beat_n = '0;
                if (wr_req) begin
                    wr_accept = 1'b1;
                    state_n   = (WR_LAT == 0) ? ST_WCOMMIT : ST_WWAIT;
                end else if (rd_req) begin
                    rd_accept = 1'b1;
                    state_n   = (RD_LAT == 0) ? ST_RBEAT : ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (lat_cnt == 4'(RD_LAT - 1)) state_n = ST_RBEAT;
                else                           lat_n   = lat_cnt + 4'd1;
            end
            ST_RBEAT: begin
                if (beat_cnt == last_beat) state_n = ST_IDLE;
                else                       beat_n  = beat_cnt + 2'd1;
            end
            ST_WWAIT: begin
                if (lat_cnt == 4'(WR_LAT - 1)) state_n = ST_WCOMMIT;
                else                           lat_n   = lat_cnt + 4'd1;
            end
            ST_WCOMMIT: begin
                ram_line_we = resetn && line_q;
                ram_word_we = resetn && !line_q;
                state_n     = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Reset forces the idle-looking outputs immediately, ending any burst.
    assign wr_rdy    = !resetn || (state == ST_IDLE);
    assign rd_rdy    = !resetn || ((state == ST_IDLE) && !wr_req);
    assign ret_valid = resetn && (state == ST_RBEAT);
    assign ret_last  = ret_valid && (beat_cnt == last_beat);
    assign ret_data  = ret_valid ? ram_rd_word : 32'd0;

    mem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_g     (clk_g),
        .rd_idx    (addr_q | {{(ADDR_W-2){1'b0}}, beat_cnt}),
        .rd_word   (ram_rd_word),
        .word_we   (ram_word_we),
        .word_idx  (addr_q),
        .word_be   (wstrb_q),
        .word_data (wdata_q[31:0]),
        .line_we   (ram_line_we),
        .line_idx  (addr_q[ADDR_W-1:2]),
        .line_data (wdata_q)
    );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed scenarios plus a
// randomized mix checked against a flat word-array memory model.
module tb_cache_mem_responder;

    localparam logic [2:0] T_WORD = 3'b010;
    localparam logic [2:0] T_LINE = 3'b100;

    logic         clk_g = 1'b0;
    logic         resetn;
    logic         rd_req, wr_req;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;

    logic        rd_rdy_a, wr_rdy_a, ret_valid_a, ret_last_a;
    logic [31:0] ret_data_a;
    logic        rd_rdy_b, wr_rdy_b, ret_valid_b, ret_last_b;
    logic [31:0] ret_data_b;

    bit          sel = 1'b0;
    logic        rd_rdy_s, wr_rdy_s, ret_valid_s, ret_last_s;
    logic [31:0] ret_data_s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [0:1023];

    always #5 clk_g = ~clk_g;

    cache_mem_responder #(.ADDR_W(10), .RD_LAT(2), .WR_LAT(2)) dut_a (
        .clk_g(clk_g), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy_a),
        .ret_valid(ret_valid_a), .ret_last(ret_last_a), .ret_data(ret_data_a),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy_a)
    );

    cache_mem_responder #(.ADDR_W(10), .RD_LAT(0), .WR_LAT(0)) dut_b (
        .clk_g(clk_g), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy_b),
        .ret_valid(ret_valid_b), .ret_last(ret_last_b), .ret_data(ret_data_b),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy_b)
    );

    assign rd_rdy_s    = sel ? rd_rdy_b    : rd_rdy_a;
    assign wr_rdy_s    = sel ? wr_rdy_b    : wr_rdy_a;
    assign ret_valid_s = sel ? ret_valid_b : ret_valid_a;
    assign ret_last_s  = sel ? ret_last_b  : ret_last_a;
    assign ret_data_s  = sel ? ret_data_b  : ret_data_a;

    // Reference memory: word index is the byte address divided by 4, modulo 1024.
    task automatic model_write(input logic [31:0] a, input logic [2:0] t,
                               input logic [3:0] s, input logic [127:0] d);
        int idx;
        idx = (a / 4) % 1024;
        if (t == T_LINE) begin
            idx = idx - (idx % 4);
            for (int k = 0; k < 4; k++) model_mem[idx + k] = d[32*k +: 32];
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Called at a falling edge; returns at the falling edge where wr_rdy is back.
    task automatic write_txn(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                             input logic [127:0] d, output bit acc, output int rdy_cyc);
        rd_req = 1'b0; wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        #1 acc = wr_rdy_s;
        @(negedge clk_g);
        wr_req = 1'b0; wr_type = 3'($urandom); wr_addr = $urandom; wr_wstrb = 4'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        rdy_cyc = -1;
        for (int c = 1; c < 40; c++) begin
            if (wr_rdy_s) begin rdy_cyc = c; break; end
            @(negedge clk_g);
        end
    endtask

    // Cycle numbers count from the accept cycle (0); quiet flags stray idle data.
    task automatic read_txn(input logic [31:0] a, input logic [2:0] t, output bit acc,
                            output int n, output logic [3:0][31:0] dat, output logic [3:0] lst,
                            output int first_cyc, output int rdy_cyc, output bit quiet);
        rd_req = 1'b1; wr_req = 1'b0; rd_type = t; rd_addr = a;
        #1 acc = rd_rdy_s;
        @(negedge clk_g);
        rd_req = 1'b0; rd_type = 3'($urandom); rd_addr = $urandom;
        n = 0; dat = '0; lst = '0; first_cyc = -1; rdy_cyc = -1; quiet = 1'b1;
        for (int c = 1; c < 60; c++) begin
            if (ret_valid_s) begin
                if (n < 4) begin dat[n] = ret_data_s; lst[n] = ret_last_s; end
                if (n == 0) first_cyc = c;
                n++;
            end else begin
                if (ret_data_s !== 32'd0 || ret_last_s !== 1'b0) quiet = 1'b0;
                if (rd_rdy_s && n > 0) begin rdy_cyc = c; break; end
            end
            @(negedge clk_g);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 40; c++) begin
            if (rd_rdy_a && wr_rdy_a && rd_rdy_b && wr_rdy_b) break;
            @(negedge clk_g);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_type = '0; wr_type = '0;
        rd_addr = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        repeat (3) @(negedge clk_g);
        n_cmp++; if (rd_rdy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_rd_rdy: got %b expected 1", rd_rdy_a); end
        n_cmp++; if (wr_rdy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_wr_rdy: got %b expected 1", wr_rdy_a); end
        n_cmp++; if (ret_valid_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ret_valid: got %b expected 0", ret_valid_a); end
        n_cmp++; if (ret_last_a !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ret_last: got %b expected 0", ret_last_a); end
        n_cmp++; if (ret_data_a !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_ret_data: got %h expected 0", ret_data_a); end
        resetn = 1'b1;
        @(negedge clk_g);
        n_cmp++; if (rd_rdy_a !== 1'b1 || ret_valid_a !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_after_reset: rdy %b valid %b expected 1 0", rd_rdy_a, ret_valid_a); end
    endtask

    task automatic test_line_rw();
        bit acc; int n, first, rdy, rc; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        logic [31:0] e;
        write_txn(32'h0000_1230, T_LINE, 4'h0,
                  {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, acc, rc);
        model_write(32'h0000_1230, T_LINE, 4'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        n_cmp++; if (acc !== 1'b1 || rc != 4) begin n_bad++; $display("[TB] FAIL line_write_timing: acc %b wr_rdy cycle %0d expected 1 4", acc, rc); end
        read_txn(32'h0000_123C, T_LINE, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (acc !== 1'b1 || n != 4) begin n_bad++; $display("[TB] FAIL line_read_beats: acc %b beats %0d expected 1 4", acc, n); end
        n_cmp++; if (first != 3 || rdy != 7) begin n_bad++; $display("[TB] FAIL line_read_timing: first %0d rdy %0d expected 3 7", first, rdy); end
        n_cmp++; if (lst !== 4'b1000) begin n_bad++; $display("[TB] FAIL line_read_last: got %b expected 1000", lst); end
        n_cmp++; if (!quiet) begin n_bad++; $display("[TB] FAIL line_read_idle_data: got nonzero expected zero"); end
        for (int k = 0; k < 4; k++) begin
            e = 32'h11111111 * (k + 1);
            n_cmp++; if (dat[k] !== e) begin n_bad++; $display("[TB] FAIL line_read_beat%0d: got %h expected %h", k, dat[k], e); end
        end
    endtask

    task automatic test_masked_write();
        bit acc; int n, first, rdy, rc; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        write_txn(32'h0000_0040, T_WORD, 4'hF, {96'd0, 32'hAABBCCDD}, acc, rc);
        write_txn(32'h0000_0040, T_WORD, 4'b0110, {96'd0, 32'h12345678}, acc, rc);
        model_write(32'h0000_0040, T_WORD, 4'hF, {96'd0, 32'hAABBCCDD});
        model_write(32'h0000_0040, T_WORD, 4'b0110, {96'd0, 32'h12345678});
        read_txn(32'h0000_0040, T_WORD, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (n != 1 || lst[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL masked_beats: beats %0d last %b expected 1 1", n, lst[0]); end
        n_cmp++; if (dat[0] !== 32'hAA3456DD) begin n_bad++; $display("[TB] FAIL masked_data: got %h expected aa3456dd", dat[0]); end
        n_cmp++; if (first != 3 || rdy != 4) begin n_bad++; $display("[TB] FAIL single_read_timing: first %0d rdy %0d expected 3 4", first, rdy); end
    endtask

    task automatic test_simultaneous();
        bit acc; int n, first, rdy, c; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        wr_req = 1'b1; wr_type = T_LINE; wr_addr = 32'h0000_0280; wr_data = d; wr_wstrb = 4'h0;
        rd_req = 1'b1; rd_type = T_LINE; rd_addr = 32'h0000_0284;
        #1;
        n_cmp++; if (rd_rdy_s !== 1'b0 || wr_rdy_s !== 1'b1) begin n_bad++; $display("[TB] FAIL collide_rdy: rd %b wr %b expected 0 1", rd_rdy_s, wr_rdy_s); end
        @(negedge clk_g);
        wr_req = 1'b0; wr_data = {$urandom, $urandom, $urandom, $urandom};
        model_write(32'h0000_0280, T_LINE, 4'h0, d);
        c = 1;
        while (!rd_rdy_s && c < 40) begin @(negedge clk_g); c++; end
        n_cmp++; if (c != 4) begin n_bad++; $display("[TB] FAIL collide_read_wait: rd_rdy cycle %0d expected 4", c); end
        read_txn(32'h0000_0284, T_LINE, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (acc !== 1'b1 || n != 4) begin n_bad++; $display("[TB] FAIL collide_read_beats: acc %b beats %0d expected 1 4", acc, n); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (dat[k] !== d[32*k +: 32]) begin n_bad++; $display("[TB] FAIL collide_beat%0d: got %h expected %h", k, dat[k], d[32*k +: 32]); end
        end
    endtask

    task automatic test_alias();
        bit acc; int n, first, rdy, rc; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        logic [31:0] r;
        r = $urandom;
        write_txn(32'h0000_1000, T_WORD, 4'hF, {96'd0, r}, acc, rc);
        model_write(32'h0000_1000, T_WORD, 4'hF, {96'd0, r});
        read_txn(32'h0000_0000, T_WORD, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (dat[0] !== r || n != 1) begin n_bad++; $display("[TB] FAIL alias_low: got %h beats %0d expected %h 1", dat[0], n, r); end
        read_txn(32'hFFFF_F003, 3'b111, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (dat[0] !== r || n != 1) begin n_bad++; $display("[TB] FAIL alias_high: got %h beats %0d expected %h 1", dat[0], n, r); end
    endtask

    task automatic test_reset_mid_burst();
        bit acc; int n, first, rdy, seen; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        rd_req = 1'b1; rd_type = T_LINE; rd_addr = 32'h0000_1230;
        @(negedge clk_g);
        rd_req = 1'b0; seen = 0;
        for (int c = 1; c < 20 && seen < 2; c++) begin
            if (ret_valid_s) seen++;
            if (seen < 2) @(negedge clk_g);
        end
        resetn = 1'b0;
        @(negedge clk_g);
        n_cmp++; if (ret_valid_a !== 1'b0 || rd_rdy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_burst: valid %b rdy %b expected 0 1", ret_valid_a, rd_rdy_a); end
        resetn = 1'b1;
        read_txn(32'h0000_1234, T_LINE, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (n != 4 || lst !== 4'b1000) begin n_bad++; $display("[TB] FAIL post_reset_burst: beats %0d last %b expected 4 1000", n, lst); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (dat[k] !== model_mem[140 + k]) begin n_bad++; $display("[TB] FAIL post_reset_beat%0d: got %h expected %h", k, dat[k], model_mem[140 + k]); end
        end
    endtask

    task automatic test_write_reset();
        bit acc; int n, first, rdy; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        wr_req = 1'b1; wr_type = T_WORD; wr_addr = 32'h0000_0040; wr_wstrb = 4'hF;
        wr_data = {96'd0, ~model_mem[16]};
        @(negedge clk_g);
        wr_req = 1'b0; resetn = 1'b0;
        @(negedge clk_g);
        resetn = 1'b1;
        read_txn(32'h0000_0040, T_WORD, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (dat[0] !== model_mem[16]) begin n_bad++; $display("[TB] FAIL write_reset_no_commit: got %h expected %h", dat[0], model_mem[16]); end
    endtask

    task automatic test_zero_latency();
        bit acc; int n, first, rdy, rc; logic [3:0][31:0] dat; logic [3:0] lst; bit quiet;
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        sel = 1'b1;
        write_txn(32'h0000_0300, T_LINE, 4'h0, d, acc, rc);
        model_write(32'h0000_0300, T_LINE, 4'h0, d);
        n_cmp++; if (acc !== 1'b1 || rc != 2) begin n_bad++; $display("[TB] FAIL lat0_write: acc %b wr_rdy cycle %0d expected 1 2", acc, rc); end
        drain();
        read_txn(32'h0000_0308, T_LINE, acc, n, dat, lst, first, rdy, quiet);
        n_cmp++; if (first != 1 || n != 4 || rdy != 5) begin n_bad++; $display("[TB] FAIL lat0_read_timing: first %0d beats %0d rdy %0d expected 1 4 5", first, n, rdy); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (dat[k] !== d[32*k +: 32]) begin n_bad++; $display("[TB] FAIL lat0_beat%0d: got %h expected %h", k, dat[k], d[32*k +: 32]); end
        end
        drain();
        sel = 1'b0;
    endtask

    task automatic test_random();
        bit acc, quiet; int n, first, rdy, rc, idx, nexp; logic [3:0][31:0] dat; logic [3:0] lst;
        logic [31:0] r, a; logic [2:0] t; logic [3:0] s; logic [127:0] d; logic [9:0] widx;
        for (int i = 0; i < 32; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            write_txn(32'(i * 16), T_LINE, 4'h0, d, acc, rc);
            model_write(32'(i * 16), T_LINE, 4'h0, d);
            n_cmp++; if (acc !== 1'b1 || rc != 4) begin n_bad++; $display("[TB] FAIL preload%0d: acc %b cycle %0d expected 1 4", i, acc, rc); end
        end
        for (int i = 0; i < 60; i++) begin
            r = $urandom; widx = 10'($urandom_range(0, 127));
            a = {r[31:12], widx, r[1:0]};
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) t = T_LINE; else if (t == T_LINE) t = T_WORD;
            if ($urandom_range(0, 1) == 1) begin
                s = 4'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
                write_txn(a, t, s, d, acc, rc);
                model_write(a, t, s, d);
                n_cmp++; if (acc !== 1'b1 || rc != 4) begin n_bad++; $display("[TB] FAIL rand_write%0d: acc %b cycle %0d expected 1 4", i, acc, rc); end
            end else begin
                read_txn(a, t, acc, n, dat, lst, first, rdy, quiet);
                idx = int'(widx);
                nexp = (t == T_LINE) ? 4 : 1;
                if (t == T_LINE) idx = idx - (idx % 4);
                n_cmp++; if (acc !== 1'b1 || n != nexp || first != 3 || rdy != 3 + nexp) begin n_bad++; $display("[TB] FAIL rand_read%0d_shape: acc %b beats %0d first %0d rdy %0d expected 1 %0d 3 %0d", i, acc, n, first, rdy, nexp, 3 + nexp); end
                n_cmp++; if (lst !== 4'(1 << (nexp - 1)) || !quiet) begin n_bad++; $display("[TB] FAIL rand_read%0d_last: got %b quiet %b expected %b 1", i, lst, quiet, 4'(1 << (nexp - 1))); end
                for (int k = 0; k < nexp; k++) begin
                    n_cmp++; if (dat[k] !== model_mem[idx + k]) begin n_bad++; $display("[TB] FAIL rand_read%0d_beat%0d: got %h expected %h", i, k, dat[k], model_mem[idx + k]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_rw();
        test_masked_write();
        test_simultaneous();
        test_alias();
        test_reset_mid_burst();
        test_write_reset();
        test_zero_latency();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the cache's refill/writeback interface. It accepts the cache's `rd_req` and `wr_req` requests and serves them from an internal word-addressed backing RAM. Line reads return as a 4-beat burst; single reads return one beat. Line writes and masked single writes take configurable latencies. It sits below `cache` in the test top, in place of the ad-hoc response logic, so the cache sees a real memory with latency and read-after-write ordering.

## Interface
- `ADDR_W`, default 10: word-index width. The RAM holds 2^ADDR_W 32-bit words (4 KB at default).
- `RD_LAT`, default 2: idle cycles between read accept and the first beat. Range 0..15.
- `WR_LAT`, default 2: idle cycles between write accept and RAM commit. Range 0..15.
- `clk_g`  in  1  clock
- `resetn`  in  1  synchronous, active-low reset
- `rd_req`  in  1  read request
- `rd_type`  in  3  000 byte, 001 half, 010 word, 100 line
- `rd_addr`  in  32  byte address
- `rd_rdy`  out  1  read request accepted this cycle if `rd_req` is also high
- `ret_valid`  out  1  read beat valid
- `ret_last`  out  1  final beat of the read
- `ret_data`  out  32  beat data
- `wr_req`  in  1  write request
- `wr_type`  in  3  encoding as `rd_type`
- `wr_addr`  in  32  byte address
- `wr_wstrb`  in  4  byte enables, single writes only
- `wr_data`  in  128  line data; `[31:0]` is used for single writes
- `wr_rdy`  out  1  write request accepted this cycle if `wr_req` is also high

## Operation
- One transaction outstanding at a time. FSM states: IDLE, RWAIT, RBEAT, WWAIT, WCOMMIT.
- `wr_rdy` = (state==IDLE).
- `rd_rdy` = (state==IDLE) && !`wr_req`. When both requests arrive together, the write wins, so a victim writeback lands before the refill read.
- Word index = `addr[ADDR_W+1:2]`. Address bits above that are ignored (memory aliases).
- Line address: `addr[3:2]` is forced to 0. Beats return words 0,1,2,3 of the 16-byte block, in that order.
- Read accept: latch the address and a line flag, then go to RWAIT. After RD_LAT cycles go to RBEAT. RD_LAT=0 goes straight to RBEAT.
- RBEAT: the beat counter goes 0..3 for a line and stays at 0 for a single read.
  - `ret_valid`=1 in every RBEAT cycle, with `ret_data` = RAM[base+cnt].
  - `ret_last` is asserted on the final beat, and the FSM returns to IDLE after it.
  - Single reads return the full aligned word. The cache does the byte/half extraction.
- Write accept: latch address, type, strobe and data, then go to WWAIT. After WR_LAT cycles go to WCOMMIT.
- WCOMMIT: a line write updates all 4 words in one cycle (`wr_wstrb` ignored). A single write updates one word under `wr_wstrb`. WCOMMIT is followed by IDLE.
- No backpressure on return: the cache must accept every beat.
- `ret_data` is 0 whenever `ret_valid`=0.
- The RAM array is not reset. `resetn` clears only FSM, counters and outputs.
- `rd_type`/`wr_type` encodings 011, 101, 110 and 111 are treated as word.

## Timing
- Output values during reset: `rd_rdy`=1, `wr_rdy`=1, `ret_valid`=0, `ret_last`=0, `ret_data`=0.
- Read accepted at edge E: beat k is valid in cycle E+RD_LAT+1+k. `rd_rdy` is high again in the cycle after the last beat.
  - Line, RD_LAT=2: beats in cycles 3..6, `rd_rdy` high in cycle 7.
- Write accepted at edge E: the RAM is updated at the end of cycle E+WR_LAT+1. `wr_rdy` is high in cycle E+WR_LAT+2.
- A read accepted in the first cycle after a write's `wr_rdy` returns sees the new data.
- Reset mid-operation: the FSM enters IDLE on the next edge. Beats stop immediately.
- A write reset before WCOMMIT makes no RAM change.
- Request inputs are sampled only on the accept cycle. Changes afterwards are ignored.

## Structure
- Package `cache_if_pkg`:
  - type codes `RT_BYTE`, `RT_HALF`, `RT_WORD`, `RT_LINE`
  - FSM state encoding
  - `LINE_BEATS`=4
- Sub-module `mem_word_ram`: 2^ADDR_W x 32, asynchronous read port, one 4-lane byte-enable write port, a 4-word line-write port, no reset. The FSM, latency counter and beat counter live in the top.

## Test plan
- Line write then line read:
  - Write `addr`=0x0000_1230, data words 0x11111111/0x22222222/0x33333333/0x44444444.
  - Line read `rd_addr`=0x0000_123C returns the same 4 words in order.
  - `ret_last` is high only on beat 4, which is cycle 6 after accept (RD_LAT=2).
- Masked single write:
  - Word 0x0000_0040 holds 0xAABBCCDD. Write 0x12345678 with `wr_wstrb`=0110.
  - Word read returns 0xAA3456DD in a single beat with `ret_last`=1.
- Simultaneous `rd_req`+`wr_req` to the same line:
  - `rd_rdy`=0 on that cycle and the write is accepted first.
  - The read is accepted after the commit and returns the new data.
- Latency sweep RD_LAT=0 and WR_LAT=0: first beat in cycle 1 after accept; `wr_rdy` back in cycle 2.
- Aliasing: a write to 0x0000_1000 (ADDR_W=10) is read back at 0x0000_0000.
- Reset mid-burst: assert `resetn`=0 after beat 2.
  - Next cycle `ret_valid`=0 and `rd_rdy`=1.
  - A subsequent line read completes with 4 beats.
